// File: rtl/sm_alu_pipe_if.sv
// Operand/result handshake bundle for sm_alu_pipe.
// The slave modport is the ALU's view; the master modport is the producer/consumer side.
interface sm_alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [1:0]       op_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_out;
  logic             sat_out;

  modport slave (
    input  in_valid, a_in, b_in, op_in, out_ready,
    output in_ready, out_valid, res_out, sat_out
  );

  modport master (
    output in_valid, a_in, b_in, op_in, out_ready,
    input  in_ready, out_valid, res_out, sat_out
  );
endinterface

// File: rtl/sm_alu_pipe.sv
// Two-stage sign-magnitude saturating add/subtract unit with valid/ready handshake.
// Optional running accumulator (ops 10/11) is enabled by defining SM_ALU_ACC_EN.
module sm_alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  sm_alu_pipe_if.slave bus
);
  localparam int M = WIDTH - 1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_adv;
  logic             s1_adv;
  logic             is_sub_in;
  logic [WIDTH-1:0] s2_res;
  logic             s2_sat;
  logic [WIDTH-1:0] res_q;
  logic             sat_q;
  logic             out_valid_q;

  // Returns {sat, sign, magnitude}; negative zero on either input is read as +0.
  function automatic logic [WIDTH:0] sm_add(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    logic [M-1:0] mx;
    logic [M-1:0] my;
    logic [M-1:0] mag;
    logic [M:0]   sum;
    logic         sx;
    logic         sy;
    logic         sgn;
    logic         sat;
    mx  = x[M-1:0];
    my  = y[M-1:0];
    sx  = x[M] & (|mx);
    sy  = y[M] & (|my);
    sum = {1'b0, mx} + {1'b0, my};
    sat = 1'b0;
    if (sx == sy) begin
      sgn = sx;
      if (sum[M]) begin
        mag = '1;
        sat = 1'b1;
      end else begin
        mag = sum[M-1:0];
      end
    end else if (mx >= my) begin
      mag = mx - my;
      sgn = sx;
    end else begin
      mag = my - mx;
      sgn = sy;
    end
    if (mag == '0) sgn = 1'b0;
    return {sat, sgn, mag};
  endfunction

  assign s2_adv       = ~out_valid_q | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.res_out  = res_q;
  assign bus.sat_out  = sat_q;

`ifdef SM_ALU_ACC_EN
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] acc;

  assign is_sub_in = (bus.op_in == 2'b01);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_op <= 2'b00;
    end else if (s1_adv && bus.in_valid) begin
      s1_op <= bus.op_in;
    end
  end

  always_comb begin
    s2_res = '0;
    s2_sat = 1'b0;
    if (s1_op == 2'b11) begin
      s2_res = {s1_a[M] & (|s1_a[M-1:0]), s1_a[M-1:0]};
    end else if (s1_op == 2'b10) begin
      {s2_sat, s2_res} = sm_add(acc, s1_a);
    end else begin
      {s2_sat, s2_res} = sm_add(s1_a, s1_b);
    end
  end

  // acc follows the S2 load, so a chained accumulate in S1 always sees the latest sum
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (s2_adv && s1_valid && s1_op[1]) begin
      acc <= s2_res;
    end
  end
`else
  logic unused_op_hi;

  assign unused_op_hi = bus.op_in[1];
  assign is_sub_in    = bus.op_in[0];

  always_comb begin
    s2_res = '0;
    s2_sat = 1'b0;
    {s2_sat, s2_res} = sm_add(s1_a, s1_b);
  end
`endif

  // Subtract is folded into S1 by flipping B's sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a <= bus.a_in;
        s1_b <= {bus.b_in[M] ^ is_sub_in, bus.b_in[M-1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      sat_q       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        res_q <= s2_res;
        sat_q <= s2_sat;
      end
    end
  end
endmodule
